// File: rtl/cache_line_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_line_pkg : shared types and codes for the cache_line block   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cache_line_pkg;

    localparam logic [1:0] WL_BYTE = 2'b00;
    localparam logic [1:0] WL_HALF = 2'b01;
    localparam logic [1:0] WL_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_line_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_line_if : request ports, controller and memory port bundle   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface cache_line_if #(
    parameter int ADDRBITS    = 32,
    parameter int DATABITS    = 32,
    parameter int TTLBITS     = 8,
    parameter int WORDLENBITS = 2
);
    logic [ADDRBITS-1:0]    dcache_line_rdaddr;
    logic                   dcache_line_rdreq;
    logic                   dcache_line_out_valid;
    logic [ADDRBITS-1:0]    dcache_line_wraddr;
    logic [DATABITS-1:0]    dcache_line_in;
    logic [WORDLENBITS-1:0] dcache_line_in_wordlen;
    logic                   dcache_line_wrreq;
    logic [ADDRBITS-1:0]    icache_line_rdaddr;
    logic                   icache_line_rdreq;
    logic                   icache_line_out_valid;
    logic [DATABITS-1:0]    cache_line_out;
    logic                   cache_line_dirty;
    logic                   cache_line_miss;
    logic                   cache_line_flush;
    logic                   cache_line_fill;
    logic                   cache_line_pause;
    logic [TTLBITS-1:0]     cache_line_ttl;
    logic [ADDRBITS-1:0]    cache_new_region;
    logic                   cache_line_ready;
    logic [ADDRBITS-1:0]    mem_addr;
    logic [DATABITS-1:0]    mem_in;
    logic [DATABITS-1:0]    mem_out;
    logic                   mem_out_valid;
    logic                   mem_wrreq;
    logic                   mem_rdreq;

    modport master (
        output dcache_line_rdaddr, dcache_line_rdreq, dcache_line_wraddr, dcache_line_in,
               dcache_line_in_wordlen, dcache_line_wrreq, icache_line_rdaddr, icache_line_rdreq,
               cache_line_flush, cache_line_fill, cache_line_pause, cache_new_region,
               mem_out, mem_out_valid,
        input  dcache_line_out_valid, icache_line_out_valid, cache_line_out, cache_line_dirty,
               cache_line_miss, cache_line_ttl, cache_line_ready, mem_addr, mem_in,
               mem_wrreq, mem_rdreq
    );

    modport slave (
        input  dcache_line_rdaddr, dcache_line_rdreq, dcache_line_wraddr, dcache_line_in,
               dcache_line_in_wordlen, dcache_line_wrreq, icache_line_rdaddr, icache_line_rdreq,
               cache_line_flush, cache_line_fill, cache_line_pause, cache_new_region,
               mem_out, mem_out_valid,
        output dcache_line_out_valid, icache_line_out_valid, cache_line_out, cache_line_dirty,
               cache_line_miss, cache_line_ttl, cache_line_ready, mem_addr, mem_in,
               mem_wrreq, mem_rdreq
    );
endinterface
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_line_store : line word array, byte-lane writes, two reads    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cache_line_store #(
    parameter int DATABITS = 32,
    parameter int IDXW     = 5
) (
    input  wire logic                  clk,
    input  wire logic [DATABITS/8-1:0] we_i,
    input  wire logic [IDXW-1:0]       widx_i,
    input  wire logic [DATABITS-1:0]   wdata_i,
    input  wire logic [IDXW-1:0]       ridx_i,
    output logic      [DATABITS-1:0]   rdata_o,
    input  wire logic [IDXW-1:0]       midx_i,
    output logic      [DATABITS-1:0]   mdata_o
);
    localparam int NB = DATABITS / 8;

    logic [DATABITS-1:0] mem_q [2**IDXW];

    // Storage is deliberately not reset; validity is tracked by the owner.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we_i[b]) begin
                mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[ridx_i];
    assign mdata_o = mem_q[midx_i];

endmodule
`default_nettype wire

// File: rtl/cache_line.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_line : single cache line with d/i read, d write, fill, flush |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cache_line
    import cache_line_pkg::*;
#(
    parameter int ADDRBITS    = 32,
    parameter int DATABITS    = 32,
    parameter int LSBBITS     = 7,
    parameter int MAXLSBVALUE = 2**LSBBITS-4,
    parameter int TTLBITS     = 8,
    parameter int MAXTTL      = 2**TTLBITS-1,
    parameter int WORDLENBITS = 2
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    cache_line_if.slave bus
);
    localparam int                 IDXW     = LSBBITS - 2;
    localparam int                 TAGW     = ADDRBITS - LSBBITS;
    localparam int                 NB       = DATABITS / 8;
    localparam logic [IDXW-1:0]    LAST_IDX = IDXW'(MAXLSBVALUE >> 2);
    localparam logic [TTLBITS-1:0] TTL_MAX  = TTLBITS'(MAXTTL);

    state_t              state_q, state_d;
    logic [TAGW-1:0]     tag_q, tag_d;
    logic                valid_q, valid_d;
    logic                dirty_q, dirty_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [TTLBITS-1:0]  ttl_q, ttl_d;
    logic [DATABITS-1:0] out_q, out_d;
    logic                dval_q, dval_d;
    logic                ival_q, ival_d;

    logic                w_usable, w_dhit_rd, w_dhit_wr, w_ihit, w_any_hit, w_any_req;
    logic                w_step, w_last;
    logic [IDXW-1:0]     w_ridx, w_widx;
    logic [NB-1:0]       w_we;
    logic [DATABITS-1:0] w_wdata, w_rdata, w_mdata;

    assign w_usable  = (state_q == IDLE) && valid_q;
    assign w_dhit_rd = w_usable && bus.dcache_line_rdreq
                       && (bus.dcache_line_rdaddr[ADDRBITS-1:LSBBITS] == tag_q);
    assign w_dhit_wr = w_usable && bus.dcache_line_wrreq
                       && (bus.dcache_line_wraddr[ADDRBITS-1:LSBBITS] == tag_q);
    assign w_ihit    = w_usable && bus.icache_line_rdreq
                       && (bus.icache_line_rdaddr[ADDRBITS-1:LSBBITS] == tag_q);
    assign w_any_hit = w_dhit_rd || w_dhit_wr || w_ihit;
    assign w_any_req = bus.dcache_line_rdreq || bus.dcache_line_wrreq || bus.icache_line_rdreq;
    assign w_last    = (idx_q == LAST_IDX);
    // One word moves per unpaused cycle: a returned memory word in FILL, a written word in a dirty FLUSH.
    assign w_step    = !bus.cache_line_pause
                       && ((state_q == FILL) ? bus.mem_out_valid : ((state_q == FLUSH) && dirty_q));
    assign w_ridx    = w_dhit_rd ? bus.dcache_line_rdaddr[LSBBITS-1:2]
                                 : bus.icache_line_rdaddr[LSBBITS-1:2];

    always_comb begin
        w_we    = '0;
        w_widx  = bus.dcache_line_wraddr[LSBBITS-1:2];
        w_wdata = bus.dcache_line_in;
        if ((state_q == FILL) && w_step) begin
            w_we    = '1;
            w_widx  = idx_q;
            w_wdata = bus.mem_out;
        end else if (w_dhit_wr) begin
            case (bus.dcache_line_in_wordlen)
                WL_BYTE: begin
                    w_we    = NB'(1) << bus.dcache_line_wraddr[1:0];
                    w_wdata = {NB{bus.dcache_line_in[7:0]}};
                end
                WL_HALF: begin
                    w_we    = NB'(3) << {bus.dcache_line_wraddr[1], 1'b0};
                    w_wdata = {(NB/2){bus.dcache_line_in[15:0]}};
                end
                default: w_we = '1;
            endcase
        end
    end

    cache_line_store #(
        .DATABITS (DATABITS),
        .IDXW     (IDXW)
    ) u_store (
        .clk     (clk),
        .we_i    (w_we),
        .widx_i  (w_widx),
        .wdata_i (w_wdata),
        .ridx_i  (w_ridx),
        .rdata_o (w_rdata),
        .midx_i  (idx_q),
        .mdata_o (w_mdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cache_line_flush)     state_d = FLUSH;
                     else if (bus.cache_line_fill) state_d = FILL;
            FILL:    if (w_step && w_last)         state_d = IDLE;
            FLUSH:   if (!dirty_q || (w_step && w_last)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        idx_d   = idx_q;
        out_d   = (w_dhit_rd || w_ihit) ? w_rdata : out_q;
        dval_d  = w_dhit_rd;
        ival_d  = w_ihit && !w_dhit_rd;
        if (w_any_hit)                   ttl_d = TTL_MAX;
        else if (valid_q && ttl_q != '0) ttl_d = ttl_q - 1'b1;
        else                             ttl_d = ttl_q;
        if (w_dhit_wr) dirty_d = 1'b1;
        case (state_q)
            IDLE: if (!bus.cache_line_flush && bus.cache_line_fill) begin
                tag_d   = bus.cache_new_region[ADDRBITS-1:LSBBITS];
                valid_d = 1'b0;
                idx_d   = '0;
            end
            FILL: if (w_step) begin
                idx_d = idx_q + 1'b1;
                if (w_last) begin
                    valid_d = 1'b1;
                    dirty_d = 1'b0;
                    ttl_d   = TTL_MAX;
                    idx_d   = '0;
                end
            end
            FLUSH: if (w_step) begin
                idx_d = idx_q + 1'b1;
                if (w_last) begin
                    dirty_d = 1'b0;
                    idx_d   = '0;
                end
            end
            default: idx_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            idx_q   <= '0;
            ttl_q   <= '0;
            out_q   <= '0;
            dval_q  <= 1'b0;
            ival_q  <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            idx_q   <= idx_d;
            ttl_q   <= ttl_d;
            out_q   <= out_d;
            dval_q  <= dval_d;
            ival_q  <= ival_d;
        end
    end

    always_comb begin
        bus.cache_line_ready      = w_usable;
        bus.cache_line_miss       = w_usable && w_any_req && !w_any_hit;
        bus.mem_rdreq             = (state_q == FILL) && !bus.cache_line_pause;
        bus.mem_wrreq             = (state_q == FLUSH) && dirty_q && !bus.cache_line_pause;
        bus.mem_addr              = (state_q != IDLE) ? {tag_q, idx_q, 2'b00} : '0;
        bus.mem_in                = ((state_q == FLUSH) && dirty_q && !bus.cache_line_pause)
                                    ? w_mdata : '0;
        bus.cache_line_out        = out_q;
        bus.dcache_line_out_valid = dval_q;
        bus.icache_line_out_valid = ival_q;
        bus.cache_line_dirty      = dirty_q;
        bus.cache_line_ttl        = ttl_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_line.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cache_line : directed + random checks against a line model      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_cache_line;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cache_line_if #(.ADDRBITS(32), .DATABITS(32), .TTLBITS(8), .WORDLENBITS(2)) bus ();

    cache_line #(
        .ADDRBITS(32), .DATABITS(32), .LSBBITS(7), .MAXLSBVALUE(124),
        .TTLBITS(8), .MAXTTL(255), .WORDLENBITS(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Backing memory: 128 words, combinational read response gated by mem_gate.
    logic [31:0] mem [0:127];
    logic        mem_gate = 1'b1;
    always_comb begin
        bus.mem_out       = mem[bus.mem_addr[8:2]];
        bus.mem_out_valid = bus.mem_rdreq && mem_gate;
    end
    always @(negedge clk) if (bus.mem_wrreq) mem[bus.mem_addr[8:2]] = bus.mem_in;

    // Reference model of the line contents and status.
    logic [31:0] m_line [0:31];
    logic [24:0] m_tag;
    bit          m_valid, m_dirty;
    int          m_ttl;
    logic [31:0] m_out;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.dcache_line_rdreq = 1'b0;
        bus.dcache_line_wrreq = 1'b0;
        bus.icache_line_rdreq = 1'b0;
    endtask

    function automatic void ttl_tick();
        if (m_valid && m_ttl > 0) m_ttl--;
    endfunction

    // One IDLE-state cycle with the given requests, checked against the model.
    task automatic cyc(input bit drd, input logic [31:0] dra, input bit dwr, input logic [31:0] dwa,
                       input logic [31:0] dwd, input logic [1:0] dwl, input bit ird,
                       input logic [31:0] ira);
        bit dh, wh, ih, exp_dv, exp_iv;
        logic [31:0] w;
        bus.dcache_line_rdreq = drd;  bus.dcache_line_rdaddr = dra;
        bus.dcache_line_wrreq = dwr;  bus.dcache_line_wraddr = dwa;
        bus.dcache_line_in = dwd;     bus.dcache_line_in_wordlen = dwl;
        bus.icache_line_rdreq = ird;  bus.icache_line_rdaddr = ira;
        #1;
        dh = m_valid && drd && (dra[31:7] == m_tag);
        wh = m_valid && dwr && (dwa[31:7] == m_tag);
        ih = m_valid && ird && (ira[31:7] == m_tag);
        check("miss", bus.cache_line_miss, 32'(m_valid && (drd || dwr || ird) && !(dh || wh || ih)));
        exp_dv = dh;
        exp_iv = ih && !dh;
        if (dh)      m_out = m_line[dra[6:2]];
        else if (ih) m_out = m_line[ira[6:2]];
        if (wh) begin
            w = m_line[dwa[6:2]];
            case (dwl)
                2'b00:   w[8*dwa[1:0] +: 8] = dwd[7:0];
                2'b01:   w[16*dwa[1] +: 16] = dwd[15:0];
                default: w = dwd;
            endcase
            m_line[dwa[6:2]] = w;
            m_dirty = 1'b1;
        end
        if (dh || wh || ih) m_ttl = 255;
        else ttl_tick();
        @(posedge clk); #1;
        check("dvalid", bus.dcache_line_out_valid, 32'(exp_dv));
        check("ivalid", bus.icache_line_out_valid, 32'(exp_iv));
        if (exp_dv || exp_iv) check("rdata", bus.cache_line_out, m_out);
        check("dirty", bus.cache_line_dirty, 32'(m_dirty));
        check("ttl", bus.cache_line_ttl, 32'(m_ttl));
        check("ready", bus.cache_line_ready, 32'(m_valid));
        clear_reqs();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill(input logic [31:0] region, input bit rnd);
        int n, ncyc;
        logic [31:0] base;
        base = {region[31:7], 7'b0};
        clear_reqs();
        bus.cache_new_region = region;
        bus.cache_line_fill = 1'b1;
        @(posedge clk); #1;
        bus.cache_line_fill = 1'b0;
        m_valid = 1'b0;
        check("fill_ready_low", bus.cache_line_ready, 0);
        n = 0;
        ncyc = 0;
        while (!bus.cache_line_ready && ncyc < 1000) begin
            mem_gate = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.cache_line_pause = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
            #1;
            if (bus.mem_rdreq) check("fill_addr", bus.mem_addr, base + 32'(n * 4));
            if (bus.mem_out_valid) n++;
            @(posedge clk); #1;
            ncyc++;
        end
        mem_gate = 1'b1;
        bus.cache_line_pause = 1'b0;
        check("fill_words", 32'(n), 32);
        if (!rnd) check("fill_cycles", 32'(ncyc), 32);
        m_tag = base[31:7];
        for (int k = 0; k < 32; k++) m_line[k] = mem[base[8:2] + 7'(k)];
        m_valid = 1'b1;
        m_dirty = 1'b0;
        m_ttl = 255;
        check("fill_ready", bus.cache_line_ready, 1);
        check("fill_ttl", bus.cache_line_ttl, 255);
        check("fill_dirty", bus.cache_line_dirty, 0);
    endtask

    task automatic flush(input bit rnd, input bit dir_pause, input bit req_during);
        int nw, ncyc, npause, diffs, exp_wr;
        logic [31:0] base;
        exp_wr = m_dirty ? 32 : 0;
        base = {m_tag, 7'b0};
        bus.cache_line_flush = 1'b1;
        bus.cache_line_fill = rnd ? bit'($urandom_range(0, 1)) : 1'b0;
        bus.cache_new_region = base ^ 32'h0000_0080;
        @(posedge clk); #1;
        ttl_tick();
        bus.cache_line_flush = 1'b0;
        bus.cache_line_fill = 1'b0;
        nw = 0;
        ncyc = 0;
        npause = 0;
        while (!bus.cache_line_ready && ncyc < 1000) begin
            if (dir_pause) bus.cache_line_pause = (ncyc >= 10 && ncyc <= 12);
            else           bus.cache_line_pause = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            bus.dcache_line_rdreq = req_during;
            bus.dcache_line_rdaddr = base + 32'h10;
            #1;
            if (req_during) check("flush_miss", bus.cache_line_miss, 0);
            if (bus.mem_wrreq) begin
                check("flush_addr", bus.mem_addr, base + 32'(nw * 4));
                check("flush_data", bus.mem_in, m_line[nw % 32]);
                nw++;
            end
            @(posedge clk); #1;
            ttl_tick();
            ncyc++;
            if (req_during) check("flush_dvalid", bus.dcache_line_out_valid, 0);
        end
        clear_reqs();
        bus.cache_line_pause = 1'b0;
        m_dirty = 1'b0;
        check("flush_writes", 32'(nw), 32'(exp_wr));
        if (dir_pause) check("flush_cycles", 32'(ncyc), 35);
        check("flush_dirty", bus.cache_line_dirty, 0);
        check("flush_ttl", bus.cache_line_ttl, 32'(m_ttl));
        diffs = 0;
        for (int k = 0; k < 32; k++) if (mem[base[8:2] + 7'(k)] !== m_line[k]) diffs++;
        check("flush_mem_image", 32'(diffs), 0);
    endtask

    function automatic logic [31:0] raddr();
        if ($urandom_range(0, 3) != 0) return {m_tag, 7'($urandom_range(0, 127))};
        return 32'($urandom_range(0, 511));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 128; k++) mem[k] = 32'h1000_0000 + 32'(k);
        clear_reqs();
        bus.dcache_line_rdaddr = '0;  bus.dcache_line_wraddr = '0;
        bus.dcache_line_in = '0;      bus.dcache_line_in_wordlen = '0;
        bus.icache_line_rdaddr = '0;  bus.cache_new_region = '0;
        bus.cache_line_flush = 1'b0;  bus.cache_line_fill = 1'b0;
        bus.cache_line_pause = 1'b0;
        m_valid = 1'b0; m_dirty = 1'b0; m_ttl = 0; m_tag = '0; m_out = '0;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.cache_line_ready, 0);
        check("rst_dirty", bus.cache_line_dirty, 0);
        check("rst_ttl", bus.cache_line_ttl, 0);
        check("rst_out", bus.cache_line_out, 0);
        check("rst_valids", {bus.dcache_line_out_valid, bus.icache_line_out_valid}, 0);
        check("rst_mem", {bus.mem_rdreq, bus.mem_wrreq}, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        cyc(1, 32'h0, 0, 0, 0, 0, 1, 32'h4);
        fill(32'h0, 0);

        cyc(0, 0, 0, 0, 0, 0, 1, 32'h08);
        check("ic_08", bus.cache_line_out, 32'h1000_0002);
        cyc(1, 32'h0C, 0, 0, 0, 0, 1, 32'h08);
        check("dc_priority", bus.cache_line_out, 32'h1000_0003);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h08);
        cyc(0, 0, 1, 32'h05, 32'h0000_00AB, 2'b00, 0, 0);
        cyc(1, 32'h04, 0, 0, 0, 0, 0, 0);
        check("byte_write", bus.cache_line_out, 32'h1000_AB01);
        cyc(1, 32'h10, 1, 32'h12, 32'h0000_BEEF, 2'b01, 0, 0);
        check("pre_write_read", bus.cache_line_out, 32'h1000_0004);
        cyc(1, 32'h10, 0, 0, 0, 0, 0, 0);
        check("half_write", bus.cache_line_out, 32'hBEEF_0004);

        flush(0, 1, 1);
        check("mem_word1", mem[1], 32'h1000_AB01);

        cyc(1, 32'h80, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h00);
        repeat (10) idle();
        check("ttl_245", bus.cache_line_ttl, 245);
        cyc(1, 32'h7C, 0, 0, 0, 0, 0, 0);
        check("ttl_reload", bus.cache_line_ttl, 255);

        for (int r = 0; r < 6; r++) begin
            fill(32'($urandom_range(0, 3)) << 7, 1);
            repeat (60) begin
                cyc(bit'($urandom_range(0, 1)), raddr(), ($urandom_range(0, 2) == 0), raddr(),
                    $urandom, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), raddr());
            end
            flush(1, 0, 0);
        end

        // Reset in the middle of a fill must drop the line and clear dirty.
        cyc(0, 0, 1, {m_tag, 7'h20}, 32'h1234_5678, 2'b10, 0, 0);
        bus.cache_new_region = 32'h100;
        bus.cache_line_fill = 1'b1;
        @(posedge clk); #1;
        bus.cache_line_fill = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midfill_rdreq", bus.mem_rdreq, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_valid = 1'b0; m_dirty = 1'b0; m_ttl = 0;
        check("abort_ready", bus.cache_line_ready, 0);
        check("abort_dirty", bus.cache_line_dirty, 0);
        check("abort_rdreq", bus.mem_rdreq, 0);
        cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
